// File: rtl/ls_wb_reg.sv
// LSU -> WB pipeline register: a two-entry skid buffer (main M, skid S).
// WB always sees M. EXU can look up forwarding data in both held entries.
module ls_wb_reg #(
    parameter logic [63:0] RST_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ls_in_valid,
    output logic        ls_in_ready,
    input  logic [63:0] in_PC,
    input  logic [63:0] in_next_PC,
    input  logic [31:0] in_inst,
    input  logic        in_trap_valid,
    input  logic        in_mret_valid,
    input  logic        in_sret_valid,
    input  logic [63:0] in_trap_cause,
    input  logic [63:0] in_trap_tval,
    input  logic        in_csr_wen,
    input  logic        in_csr_ren,
    input  logic [11:0] in_csr_addr,
    input  logic [4:0]  in_rd,
    input  logic        in_dest_wen,
    input  logic [63:0] in_data,
    output logic        LS_WB_reg_ls_valid,
    output logic [63:0] LS_WB_reg_PC,
    output logic [63:0] LS_WB_reg_next_PC,
    output logic [31:0] LS_WB_reg_inst,
    output logic        LS_WB_reg_trap_valid,
    output logic        LS_WB_reg_mret_valid,
    output logic        LS_WB_reg_sret_valid,
    output logic [63:0] LS_WB_reg_trap_cause,
    output logic [63:0] LS_WB_reg_trap_tval,
    output logic        LS_WB_reg_csr_wen,
    output logic        LS_WB_reg_csr_ren,
    output logic [11:0] LS_WB_reg_csr_addr,
    output logic [4:0]  LS_WB_reg_rd,
    output logic        LS_WB_reg_dest_wen,
    output logic [63:0] LS_WB_reg_data,
    input  logic        WB_LS_ls_ready,
    input  logic        WB_LS_flush_flag,
    input  logic [4:0]  fwd_rs1,
    input  logic [4:0]  fwd_rs2,
    output logic        fwd_rs1_hit,
    output logic        fwd_rs2_hit,
    output logic [63:0] fwd_rs1_data,
    output logic [63:0] fwd_rs2_data,
    output logic        fwd_stall,
    output logic [1:0]  ls_occupancy
);

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] next_pc;
        logic [31:0] inst;
        logic        trap_valid;
        logic        mret_valid;
        logic        sret_valid;
        logic [63:0] trap_cause;
        logic [63:0] trap_tval;
        logic        csr_wen;
        logic        csr_ren;
        logic [11:0] csr_addr;
        logic [4:0]  rd;
        logic        dest_wen;
        logic [63:0] data;
    } entry_t;

    // The state value doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    entry_t m_q;
    entry_t s_q;
    entry_t in_e;
    logic   m_valid;
    logic   s_valid;
    logic   acc;
    logic   ret;
    logic   stall1;
    logic   stall2;

    assign in_e = {in_PC, in_next_PC, in_inst, in_trap_valid, in_mret_valid, in_sret_valid,
                   in_trap_cause, in_trap_tval, in_csr_wen, in_csr_ren, in_csr_addr,
                   in_rd, in_dest_wen, in_data};

    assign m_valid      = (state != EMPTY);
    assign s_valid      = (state == FULL);
    assign ls_in_ready  = !s_valid;
    assign ls_occupancy = state;
    assign acc          = ls_in_valid && ls_in_ready;
    assign ret          = m_valid && WB_LS_ls_ready;

    // A flush means WB is committing M; everything younger is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            m_q          <= '0;
            m_q.pc       <= RST_PC;
            m_q.next_pc  <= RST_PC;
            s_q          <= '0;
        end else if (WB_LS_flush_flag) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        m_q   <= in_e;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (acc && ret) begin
                        m_q <= in_e;
                    end else if (acc) begin
                        s_q   <= in_e;
                        state <= FULL;
                    end else if (ret) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (ret) begin
                        m_q   <= s_q;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign LS_WB_reg_ls_valid   = m_valid;
    assign LS_WB_reg_PC         = m_q.pc;
    assign LS_WB_reg_next_PC    = m_q.next_pc;
    assign LS_WB_reg_inst       = m_q.inst;
    assign LS_WB_reg_trap_valid = m_q.trap_valid;
    assign LS_WB_reg_mret_valid = m_q.mret_valid;
    assign LS_WB_reg_sret_valid = m_q.sret_valid;
    assign LS_WB_reg_trap_cause = m_q.trap_cause;
    assign LS_WB_reg_trap_tval  = m_q.trap_tval;
    assign LS_WB_reg_csr_wen    = m_q.csr_wen;
    assign LS_WB_reg_csr_ren    = m_q.csr_ren;
    assign LS_WB_reg_csr_addr   = m_q.csr_addr;
    assign LS_WB_reg_rd         = m_q.rd;
    assign LS_WB_reg_dest_wen   = m_q.dest_wen;
    assign LS_WB_reg_data       = m_q.data;

    // Returns {stall, hit, data}. S is younger than M, so it wins.
    function automatic logic [65:0] lookup(input logic [4:0] rs,
                                           input entry_t m, input logic mv,
                                           input entry_t s, input logic sv);
        logic s_match;
        logic m_match;
        s_match = sv && s.dest_wen && !s.trap_valid && (s.rd == rs) && (rs != 5'd0);
        m_match = mv && m.dest_wen && !m.trap_valid && (m.rd == rs) && (rs != 5'd0);
        lookup  = '0;
        if (s_match) begin
            lookup = s.csr_ren ? {2'b10, 64'h0} : {2'b01, s.data};
        end else if (m_match) begin
            lookup = m.csr_ren ? {2'b10, 64'h0} : {2'b01, m.data};
        end
    endfunction

    assign {stall1, fwd_rs1_hit, fwd_rs1_data} = lookup(fwd_rs1, m_q, m_valid, s_q, s_valid);
    assign {stall2, fwd_rs2_hit, fwd_rs2_data} = lookup(fwd_rs2, m_q, m_valid, s_q, s_valid);
    assign fwd_stall = stall1 || stall2;

endmodule

// File: tb/tb_ls_wb_reg.sv
// Randomized scoreboard bench for ls_wb_reg: a FIFO model predicts retirements,
// occupancy and forwarding; a negedge monitor checks every beat WB accepts.
module tb_ls_wb_reg;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] next_pc;
        logic [31:0] inst;
        logic        trap_valid;
        logic        mret_valid;
        logic        sret_valid;
        logic [63:0] trap_cause;
        logic [63:0] trap_tval;
        logic        csr_wen;
        logic        csr_ren;
        logic [11:0] csr_addr;
        logic [4:0]  rd;
        logic        dest_wen;
        logic [63:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ls_in_valid;
    logic        ls_in_ready;
    logic [63:0] in_PC, in_next_PC, in_trap_cause, in_trap_tval, in_data;
    logic [31:0] in_inst;
    logic        in_trap_valid, in_mret_valid, in_sret_valid, in_csr_wen, in_csr_ren, in_dest_wen;
    logic [11:0] in_csr_addr;
    logic [4:0]  in_rd;
    logic        LS_WB_reg_ls_valid;
    logic [63:0] LS_WB_reg_PC, LS_WB_reg_next_PC, LS_WB_reg_trap_cause, LS_WB_reg_trap_tval, LS_WB_reg_data;
    logic [31:0] LS_WB_reg_inst;
    logic        LS_WB_reg_trap_valid, LS_WB_reg_mret_valid, LS_WB_reg_sret_valid;
    logic        LS_WB_reg_csr_wen, LS_WB_reg_csr_ren, LS_WB_reg_dest_wen;
    logic [11:0] LS_WB_reg_csr_addr;
    logic [4:0]  LS_WB_reg_rd;
    logic        WB_LS_ls_ready;
    logic        WB_LS_flush_flag;
    logic [4:0]  fwd_rs1, fwd_rs2;
    logic        fwd_rs1_hit, fwd_rs2_hit, fwd_stall;
    logic [63:0] fwd_rs1_data, fwd_rs2_data;
    logic [1:0]  ls_occupancy;

    beat_t drv;
    beat_t act;
    beat_t mdl[$];
    beat_t exp_q[$];
    int    compared = 0;
    int    mismatched = 0;

    assign {in_PC, in_next_PC, in_inst, in_trap_valid, in_mret_valid, in_sret_valid,
            in_trap_cause, in_trap_tval, in_csr_wen, in_csr_ren, in_csr_addr,
            in_rd, in_dest_wen, in_data} = drv;
    assign act = {LS_WB_reg_PC, LS_WB_reg_next_PC, LS_WB_reg_inst, LS_WB_reg_trap_valid,
                  LS_WB_reg_mret_valid, LS_WB_reg_sret_valid, LS_WB_reg_trap_cause,
                  LS_WB_reg_trap_tval, LS_WB_reg_csr_wen, LS_WB_reg_csr_ren,
                  LS_WB_reg_csr_addr, LS_WB_reg_rd, LS_WB_reg_dest_wen, LS_WB_reg_data};

    ls_wb_reg #(.RST_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .ls_in_valid(ls_in_valid), .ls_in_ready(ls_in_ready),
        .in_PC(in_PC), .in_next_PC(in_next_PC), .in_inst(in_inst),
        .in_trap_valid(in_trap_valid), .in_mret_valid(in_mret_valid), .in_sret_valid(in_sret_valid),
        .in_trap_cause(in_trap_cause), .in_trap_tval(in_trap_tval),
        .in_csr_wen(in_csr_wen), .in_csr_ren(in_csr_ren), .in_csr_addr(in_csr_addr),
        .in_rd(in_rd), .in_dest_wen(in_dest_wen), .in_data(in_data),
        .LS_WB_reg_ls_valid(LS_WB_reg_ls_valid),
        .LS_WB_reg_PC(LS_WB_reg_PC), .LS_WB_reg_next_PC(LS_WB_reg_next_PC), .LS_WB_reg_inst(LS_WB_reg_inst),
        .LS_WB_reg_trap_valid(LS_WB_reg_trap_valid), .LS_WB_reg_mret_valid(LS_WB_reg_mret_valid),
        .LS_WB_reg_sret_valid(LS_WB_reg_sret_valid), .LS_WB_reg_trap_cause(LS_WB_reg_trap_cause),
        .LS_WB_reg_trap_tval(LS_WB_reg_trap_tval), .LS_WB_reg_csr_wen(LS_WB_reg_csr_wen),
        .LS_WB_reg_csr_ren(LS_WB_reg_csr_ren), .LS_WB_reg_csr_addr(LS_WB_reg_csr_addr),
        .LS_WB_reg_rd(LS_WB_reg_rd), .LS_WB_reg_dest_wen(LS_WB_reg_dest_wen), .LS_WB_reg_data(LS_WB_reg_data),
        .WB_LS_ls_ready(WB_LS_ls_ready), .WB_LS_flush_flag(WB_LS_flush_flag),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
        .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
        .fwd_stall(fwd_stall), .ls_occupancy(ls_occupancy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference forwarding: scan held beats youngest-first for a usable writer of rs.
    task automatic model_fwd(input logic [4:0] rs, output logic hit, output logic stall, output logic [63:0] data);
        hit = 1'b0;
        stall = 1'b0;
        data = '0;
        if (rs != 5'd0) begin
            for (int i = mdl.size() - 1; i >= 0; i--) begin
                if (mdl[i].dest_wen && !mdl[i].trap_valid && mdl[i].rd == rs) begin
                    if (mdl[i].csr_ren) stall = 1'b1;
                    else begin
                        hit = 1'b1;
                        data = mdl[i].data;
                    end
                    break;
                end
            end
        end
    endtask

    task automatic check_fwd(input logic [4:0] rs1, input logic [4:0] rs2);
        logic h1, h2, s1, s2;
        logic [63:0] d1, d2;
        fwd_rs1 = rs1;
        fwd_rs2 = rs2;
        #1;
        model_fwd(rs1, h1, s1, d1);
        model_fwd(rs2, h2, s2, d2);
        check_eq("fwd_rs1_hit", 64'(fwd_rs1_hit), 64'(h1));
        check_eq("fwd_rs2_hit", 64'(fwd_rs2_hit), 64'(h2));
        check_eq("fwd_stall", 64'(fwd_stall), 64'(s1 | s2));
        if (h1) check_eq("fwd_rs1_data", fwd_rs1_data, d1);
        if (h2) check_eq("fwd_rs2_data", fwd_rs2_data, d2);
    endtask

    task automatic check_output();
        check_eq("ls_occupancy", 64'(ls_occupancy), 64'(mdl.size()));
        check_eq("ls_in_ready", 64'(ls_in_ready), 64'(mdl.size() < 2));
        check_eq("ls_valid", 64'(LS_WB_reg_ls_valid), 64'(mdl.size() > 0));
        check_fwd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    endtask

    // Called shortly after a rising edge; drives one cycle and advances the model.
    task automatic apply_stimulus(input logic v, input beat_t b, input logic rdy, input logic fl);
        int  n;
        logic acc, ret;
        ls_in_valid = v;
        drv = b;
        WB_LS_ls_ready = rdy;
        WB_LS_flush_flag = fl;
        n = mdl.size();
        acc = v && (n < 2);
        ret = rdy && (n > 0);
        if (ret) exp_q.push_back(mdl[0]);
        @(posedge clk);
        #1;
        if (fl) mdl.delete();
        else begin
            if (ret) void'(mdl.pop_front());
            if (acc) mdl.push_back(b);
        end
        ls_in_valid = 1'b0;
        WB_LS_flush_flag = 1'b0;
        check_output();
    endtask

    function automatic beat_t rand_beat(input logic [63:0] pc);
        beat_t b;
        b.pc = pc;
        b.next_pc = pc + 64'd4;
        b.inst = $urandom;
        b.trap_valid = ($urandom_range(0, 7) == 0);
        b.mret_valid = 1'($urandom_range(0, 1));
        b.sret_valid = 1'($urandom_range(0, 1));
        b.trap_cause = {$urandom, $urandom};
        b.trap_tval = {$urandom, $urandom};
        b.csr_wen = 1'($urandom_range(0, 1));
        b.csr_ren = ($urandom_range(0, 5) == 0);
        b.csr_addr = 12'($urandom);
        b.rd = 5'($urandom_range(0, 7));
        b.dest_wen = ($urandom_range(0, 3) != 0);
        b.data = {$urandom, $urandom};
        return b;
    endfunction

    function automatic beat_t writer(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] data,
                                     input logic csr_ren, input logic trap);
        beat_t b;
        b = rand_beat(pc);
        b.rd = rd;
        b.data = data;
        b.dest_wen = 1'b1;
        b.csr_ren = csr_ren;
        b.trap_valid = trap;
        return b;
    endfunction

    task automatic drain();
        int guard = 0;
        while (mdl.size() > 0 && guard < 8) begin
            apply_stimulus(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        check_eq("drain_empty", 64'(mdl.size()), 64'd0);
    endtask

    // Monitor: every beat WB accepts must be the next one the model expects.
    always @(negedge clk) begin
        if (rst_n) begin
            if (LS_WB_reg_ls_valid && WB_LS_ls_ready) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL retire_unexpected: got PC %h, expected no beat at %0t", act.pc, $time);
                end else if (act !== exp_q[0]) begin
                    mismatched++;
                    $display("[TB] FAIL retire_payload: got %h, expected %h", act, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end else if (exp_q.size() > 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL retire_missing: got valid %b, expected PC %h at %0t",
                         LS_WB_reg_ls_valid, exp_q[0].pc, $time);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        beat_t a, b;
        rst_n = 1'b0;
        ls_in_valid = 1'b0;
        drv = '0;
        WB_LS_ls_ready = 1'b0;
        WB_LS_flush_flag = 1'b0;
        fwd_rs1 = 5'd0;
        fwd_rs2 = 5'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_occupancy", 64'(ls_occupancy), 64'd0);
        check_eq("rst_in_ready", 64'(ls_in_ready), 64'd1);
        check_eq("rst_ls_valid", 64'(LS_WB_reg_ls_valid), 64'd0);
        check_eq("rst_PC", LS_WB_reg_PC, RST_PC);
        check_eq("rst_next_PC", LS_WB_reg_next_PC, RST_PC);
        check_eq("rst_data", LS_WB_reg_data, 64'd0);
        check_fwd(5'd5, 5'd3);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output();

        $display("[TB] back-to-back beats with WB ready");
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b1, rand_beat(64'h8000_0000 + 64'(4 * i)), 1'b1, 1'b0);
        drain();

        $display("[TB] back-pressure fills skid, then releases in order");
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b1, rand_beat(64'h9000_0000 + 64'(4 * i)), 1'b0, 1'b0);
        check_eq("full_in_ready", 64'(ls_in_ready), 64'd0);
        b = rand_beat(64'h9000_0008);
        apply_stimulus(1'b1, b, 1'b1, 1'b0);
        apply_stimulus(1'b1, b, 1'b1, 1'b0);
        drain();

        $display("[TB] flush while full with a beat offered");
        apply_stimulus(1'b1, rand_beat(64'hA000_0000), 1'b0, 1'b0);
        apply_stimulus(1'b1, rand_beat(64'hA000_0004), 1'b0, 1'b0);
        apply_stimulus(1'b1, rand_beat(64'hA000_0008), 1'b1, 1'b1);
        check_eq("flush_occupancy", 64'(ls_occupancy), 64'd0);

        $display("[TB] forwarding priority and CSR stall");
        a = writer(64'hB000_0000, 5'd5, 64'h11, 1'b0, 1'b0);
        b = writer(64'hB000_0004, 5'd5, 64'h22, 1'b0, 1'b0);
        apply_stimulus(1'b1, a, 1'b0, 1'b0);
        apply_stimulus(1'b1, b, 1'b0, 1'b0);
        check_fwd(5'd5, 5'd0);
        check_eq("fwd_young_data", fwd_rs1_data, 64'h22);
        drain();
        apply_stimulus(1'b1, writer(64'hB000_0008, 5'd7, 64'h33, 1'b0, 1'b0), 1'b0, 1'b0);
        apply_stimulus(1'b1, writer(64'hB000_000C, 5'd7, 64'h44, 1'b1, 1'b0), 1'b0, 1'b0);
        check_fwd(5'd3, 5'd7);
        drain();
        apply_stimulus(1'b1, writer(64'hB000_0010, 5'd9, 64'h55, 1'b0, 1'b1), 1'b0, 1'b0);
        check_fwd(5'd9, 5'd9);
        drain();

        $display("[TB] asynchronous reset while full");
        apply_stimulus(1'b1, rand_beat(64'hC000_0000), 1'b0, 1'b0);
        apply_stimulus(1'b1, rand_beat(64'hC000_0004), 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_occupancy", 64'(ls_occupancy), 64'd0);
        check_eq("arst_in_ready", 64'(ls_in_ready), 64'd1);
        check_eq("arst_ls_valid", 64'(LS_WB_reg_ls_valid), 64'd0);
        check_eq("arst_PC", LS_WB_reg_PC, RST_PC);
        mdl.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            logic v, rdy, fl;
            v = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 6);
            fl = ($urandom_range(0, 19) == 0);
            if (fl) rdy = 1'b1;
            apply_stimulus(v, rand_beat(64'hD000_0000 + 64'(4 * i)), rdy, fl);
        end
        drain();
        WB_LS_ls_ready = 1'b0;
        @(negedge clk);
        check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
